// File: rtl/isolde_vlen_pkg.sv
// Shared constants, types and header length decode for the ISOLDE variable-length assembler.
package isolde_vlen_pkg;

  localparam int unsigned VLEN_WORDS_MAX = 8;

  localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
  localparam logic [6:0] OPC_CUSTOM1 = 7'h2B;
  localparam logic [6:0] OPC_VLEN    = 7'h7B;

  typedef enum logic {
    VLEN_IDLE,
    VLEN_COLLECT
  } vlen_state_e;

  typedef struct packed {
    logic [VLEN_WORDS_MAX-1:0][31:0] words;
    logic [3:0]                      len;
  } vlen_entry_t;

  // Length in words; 0 marks an unknown opcode. The MAX_WORDS bound is applied by the caller.
  function automatic logic [3:0] vlen_len(input logic [6:0] opcode, input logic [2:0] func3);
    logic [3:0] len;
    len = 4'd0;
    if (opcode == OPC_CUSTOM0 || opcode == OPC_CUSTOM1) begin
      len = 4'd1;
    end else if (opcode == OPC_VLEN) begin
      len = {1'b0, func3} + 4'd1;
    end
    return len;
  endfunction

endpackage

// File: rtl/isolde_vlen_queue.sv
// Small FIFO of assembled instructions; flush empties it on the next edge.
module isolde_vlen_queue #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = isolde_vlen_pkg::vlen_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= entry_i;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop) r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/isolde_vlen_assembler.sv
// Variable-length custom-instruction assembler with an output queue.
// Optional statistics counters are enabled with ISOLDE_VLEN_STATS_EN.
module isolde_vlen_assembler
  import isolde_vlen_pkg::*;
#(
  parameter int unsigned MAX_WORDS   = 8,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_word_i,
  output logic                   out_req_o,
  input  logic                   out_gnt_i,
  output logic [MAX_WORDS*32-1:0] out_words_o,
  output logic [3:0]             out_len_o,
  output logic                   illegal_o,
  output logic [31:0]            illegal_word_o,
  output logic                   busy_o
`ifdef ISOLDE_VLEN_STATS_EN
  ,
  output logic [31:0]            stat_instr_o,
  output logic [31:0]            stat_illegal_o,
  output logic [31:0]            stat_stall_o
`endif
);

  vlen_state_e r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [3:0]  r_len, w_len_next;
  logic        r_illegal;
  logic [31:0] r_illegal_word;

  logic        w_accept, w_hdr_legal, w_push, w_pop, w_start, w_collect, w_illegal;
  logic [3:0]  w_hdr_len, w_push_len;
  logic        w_q_full, w_q_empty;
  logic [VLEN_WORDS_MAX-1:0][31:0] w_push_words;
  vlen_entry_t w_entry, w_head;

  assign in_ready_o  = !w_q_full && !flush_i;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_hdr_len   = vlen_len(in_word_i[6:0], in_word_i[14:12]);
  assign w_hdr_legal = (w_hdr_len != 4'd0) && (w_hdr_len <= 4'(MAX_WORDS));
  assign out_req_o   = !w_q_empty;
  assign w_pop       = out_req_o && out_gnt_i;
  assign busy_o      = (r_state == VLEN_COLLECT) || !w_q_empty;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    w_push       = 1'b0;
    w_push_len   = r_len;
    w_start      = 1'b0;
    w_collect    = 1'b0;
    w_illegal    = 1'b0;
    if (flush_i) begin
      w_state_next = VLEN_IDLE;
    end else if (w_accept) begin
      case (r_state)
        VLEN_IDLE: begin
          if (!w_hdr_legal) begin
            w_illegal = 1'b1;
          end else if (w_hdr_len == 4'd1) begin
            w_push     = 1'b1;
            w_push_len = 4'd1;
          end else begin
            w_start      = 1'b1;
            w_cnt_next   = 4'd1;
            w_len_next   = w_hdr_len;
            w_state_next = VLEN_COLLECT;
          end
        end
        VLEN_COLLECT: begin
          // Payload words are never decoded, even if they look like headers.
          w_collect  = 1'b1;
          w_cnt_next = r_cnt + 4'd1;
          if (r_cnt == r_len - 4'd1) begin
            w_push       = 1'b1;
            w_state_next = VLEN_IDLE;
          end
        end
        default: w_state_next = VLEN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= VLEN_IDLE;
      r_cnt          <= '0;
      r_len          <= '0;
      r_illegal      <= 1'b0;
      r_illegal_word <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_len     <= w_len_next;
      r_illegal <= w_illegal;
      if (w_illegal) r_illegal_word <= in_word_i;
    end
  end

  assign illegal_o      = r_illegal;
  assign illegal_word_o = r_illegal_word;

  // The word arriving this cycle is merged into the pushed entry so completion costs no extra cycle.
  for (genvar gi = 0; gi < VLEN_WORDS_MAX; gi++) begin : g_word
    if (gi < MAX_WORDS) begin : g_used
      logic [31:0] r_word;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_word <= '0;
        else if (w_start) r_word <= (gi == 0) ? in_word_i : '0;
        else if (w_collect && r_cnt == 4'(gi)) r_word <= in_word_i;
      end
      assign w_push_words[gi] = (r_state == VLEN_IDLE) ? ((gi == 0) ? in_word_i : '0)
                                : ((r_cnt == 4'(gi)) ? in_word_i : r_word);
      assign out_words_o[gi*32 +: 32] = w_q_empty ? '0 : w_head.words[gi];
    end else begin : g_unused
      assign w_push_words[gi] = '0;
    end
  end

  assign w_entry   = '{words: w_push_words, len: w_push_len};
  assign out_len_o = w_q_empty ? 4'd0 : w_head.len;

  isolde_vlen_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .entry_t(vlen_entry_t)
  ) u_queue (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush_i),
    .push_i (w_push),
    .entry_i(w_entry),
    .pop_i  (w_pop),
    .head_o (w_head),
    .full_o (w_q_full),
    .empty_o(w_q_empty)
  );

`ifdef ISOLDE_VLEN_STATS_EN
  logic [31:0] r_stat_instr, r_stat_illegal, r_stat_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_instr   <= '0;
      r_stat_illegal <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_pop && !(&r_stat_instr)) r_stat_instr <= r_stat_instr + 32'd1;
      if (w_illegal && !(&r_stat_illegal)) r_stat_illegal <= r_stat_illegal + 32'd1;
      if (in_valid_i && !in_ready_o && !(&r_stat_stall)) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_instr_o   = r_stat_instr;
  assign stat_illegal_o = r_stat_illegal;
  assign stat_stall_o   = r_stat_stall;
`endif

endmodule

// File: tb/tb_isolde_vlen_assembler.sv
// Randomized scoreboard bench: a word-stream model predicts queued instructions, a monitor checks them.
module tb_isolde_vlen_assembler;

  localparam int MAXW  = 4;
  localparam int DEPTH = 2;
  localparam int NUM_INSTR = 300;
  localparam int MAX_CYCLES = 20000;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 flush_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [31:0]          in_word_i;
  logic                 out_req_o;
  logic                 out_gnt_i;
  logic [MAXW*32-1:0]   out_words_o;
  logic [3:0]           out_len_o;
  logic                 illegal_o;
  logic [31:0]          illegal_word_o;
  logic                 busy_o;
`ifdef ISOLDE_VLEN_STATS_EN
  logic [31:0]          stat_instr_o, stat_illegal_o, stat_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  isolde_vlen_assembler #(
    .MAX_WORDS  (MAXW),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_word_i     (in_word_i),
    .out_req_o     (out_req_o),
    .out_gnt_i     (out_gnt_i),
    .out_words_o   (out_words_o),
    .out_len_o     (out_len_o),
    .illegal_o     (illegal_o),
    .illegal_word_o(illegal_word_o),
    .busy_o        (busy_o)
`ifdef ISOLDE_VLEN_STATS_EN
    ,
    .stat_instr_o  (stat_instr_o),
    .stat_illegal_o(stat_illegal_o),
    .stat_stall_o  (stat_stall_o)
`endif
  );

  typedef struct {
    logic [MAXW*32-1:0] words;
    int                 len;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  exp_t        exp_q[$];
  logic [31:0] stream[$];
  logic [31:0] pend[$];
  int          pend_len;
  int          m_count;
  logic        exp_illegal;
  logic [31:0] exp_ill_word;
  int          m_instr, m_ill, m_stall;
  bit          m_pop, m_fire, m_ready;

  task automatic chk(input string nm, input logic [MAXW*32-1:0] act, input logic [MAXW*32-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level length rule: 0 means illegal.
  function automatic int spec_len(input logic [31:0] w);
    int l;
    l = 0;
    if (w[6:0] == 7'h0B || w[6:0] == 7'h2B) l = 1;
    else if (w[6:0] == 7'h7B) l = int'(w[14:12]) + 1;
    if (l > MAXW) l = 0;
    return l;
  endfunction

  function automatic exp_t make_entry();
    exp_t e;
    e.words = '0;
    for (int i = 0; i < pend.size(); i++) e.words[i*32 +: 32] = pend[i];
    e.len = pend.size();
    return e;
  endfunction

  // Reference model: consumes accepted words at each edge.
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_count = 0; pend.delete(); pend_len = 0; exp_q.delete();
      exp_illegal = 1'b0; exp_ill_word = '0;
      m_instr = 0; m_ill = 0; m_stall = 0;
    end else begin
      m_ready = (m_count < DEPTH) && !flush_i;
      m_pop   = (m_count > 0) && out_gnt_i;
      m_fire  = in_valid_i && m_ready;
      if (in_valid_i && !m_ready) m_stall++;
      if (m_pop) m_instr++;
      exp_illegal = 1'b0;
      if (m_pop) m_count--;
      if (m_fire) begin
        if (pend.size() == 0) begin
          pend_len = spec_len(in_word_i);
          if (pend_len == 0) begin
            exp_illegal = 1'b1; exp_ill_word = in_word_i; m_ill++;
          end else begin
            pend.push_back(in_word_i);
          end
        end else begin
          pend.push_back(in_word_i);
        end
        if (pend.size() > 0 && pend.size() == pend_len) begin
          exp_q.push_back(make_entry());
          m_count++;
          pend.delete();
        end
      end
      if (flush_i) begin
        exp_q.delete(); pend.delete(); m_count = 0;
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle and retires granted heads.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("in_ready", in_ready_o, (m_count < DEPTH) && !flush_i);
      chk("out_req", out_req_o, m_count > 0);
      chk("illegal", illegal_o, exp_illegal);
      chk("illegal_word", illegal_word_o, exp_ill_word);
      chk("busy", busy_o, (pend.size() > 0) || (m_count > 0));
      if (out_req_o && out_gnt_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL pop_unexpected: got len %0d expected no request at %0t", out_len_o, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("head_len", out_len_o, e.len);
          chk("head_words", out_words_o, e.words);
          n_pop++;
          $display("pop %0d: len=%0d hdr=%h", n_pop, out_len_o, out_words_o[31:0]);
        end
      end
    end
  end

  initial begin
    int   cyc;
    bit   fire;
    int   kind;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [31:0] r;

    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_word_i = '0; out_gnt_i = 1'b0;

    for (int k = 0; k < NUM_INSTR; k++) begin
      kind = $urandom_range(9);
      f3 = 3'($urandom_range(7));
      if (kind <= 2) opc = 7'h0B;
      else if (kind == 3) opc = 7'h2B;
      else if (kind <= 8) opc = 7'h7B;
      else begin
        do opc = 7'($urandom_range(127)); while (opc == 7'h0B || opc == 7'h2B || opc == 7'h7B);
      end
      r = $urandom;
      stream.push_back({r[31:15], f3, r[11:7], opc});
      if (opc == 7'h7B && int'(f3) + 1 <= MAXW)
        for (int p = 0; p < int'(f3); p++) stream.push_back($urandom);
    end

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_out_req", out_req_o, 1'b0);
    chk("rst_out_words", out_words_o, '0);
    chk("rst_out_len", out_len_o, 4'd0);
    chk("rst_illegal", illegal_o, 1'b0);
    chk("rst_illegal_word", illegal_word_o, 32'd0);
    chk("rst_busy", busy_o, 1'b0);

    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc = 0;
    fire = 1'b0;
    while (1) begin
      @(posedge clk_i); #1;
      if (fire) void'(stream.pop_front());
      if (stream.size() == 0) break;
      if (cyc >= MAX_CYCLES) begin
        n_cmp++; n_err++;
        $display("FAIL timeout: %0d words left after %0d cycles", stream.size(), cyc);
        break;
      end
      case ((cyc / 150) % 3)
        0: out_gnt_i = 1'b1;
        1: out_gnt_i = ($urandom_range(99) < 40);
        default: out_gnt_i = ((cyc % 50) >= 40);
      endcase
      flush_i    = ($urandom_range(99) < 2);
      in_valid_i = ($urandom_range(99) < 85);
      in_word_i  = stream[0];
      @(negedge clk_i);
      fire = in_valid_i && in_ready_o;
      cyc++;
    end

    in_valid_i = 1'b0; flush_i = 1'b0; out_gnt_i = 1'b1;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d outstanding entries expected 0", exp_q.size());
    end
    chk("drain_busy", busy_o, 1'b0);
`ifdef ISOLDE_VLEN_STATS_EN
    chk("stat_instr", stat_instr_o, m_instr);
    chk("stat_illegal", stat_illegal_o, m_ill);
    chk("stat_stall", stat_stall_o, m_stall);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
